// File: rtl/control_pkg.sv
// Shared types and encodings for the accumulator processor control path:
// FSM states, opcodes, accumulator source and ALU operation codes.
package control_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_MEM    = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;
    localparam logic [4:0] OP_BEQ  = 5'b01000;
    localparam logic [4:0] OP_BNE  = 5'b01001;
    localparam logic [4:0] OP_BGT  = 5'b01010;
    localparam logic [4:0] OP_BGE  = 5'b01011;
    localparam logic [4:0] OP_BLT  = 5'b01100;
    localparam logic [4:0] OP_BLE  = 5'b01101;
    localparam logic [4:0] OP_JMP  = 5'b01110;

    localparam logic [1:0] ACC_SRC_ALU = 2'b00;
    localparam logic [1:0] ACC_SRC_MEM = 2'b01;
    localparam logic [1:0] ACC_SRC_IMM = 2'b10;

    localparam logic ALU_SOMA = 1'b0;
    localparam logic ALU_SUBT = 1'b1;

    // Instructions whose operand must be read from data memory first.
    function automatic logic needs_mem_read(input logic [4:0] op);
        return (op == OP_LD) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // Instructions that update the architectural zero/sign flags.
    function automatic logic is_arith(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_ADDI) || (op == OP_SUB) || (op == OP_SUBI);
    endfunction

endpackage

// File: rtl/control_unit_branch_resolver.sv
// Combinational branch decision from the opcode and the registered Z/N flags.
// JMP resolves as always taken; non-branch opcodes never take.
module branch_resolver
    import control_pkg::*;
(
    input  logic [4:0] opcode,
    input  logic       zero_flag,
    input  logic       sign_flag,
    output logic       take_branch
);

    // Condition table evaluated on the flags of the last arithmetic instruction.
    always_comb begin
        take_branch = 1'b0;
        case (opcode)
            OP_BEQ:  take_branch = zero_flag;
            OP_BNE:  take_branch = ~zero_flag;
            OP_BGT:  take_branch = ~zero_flag & ~sign_flag;
            OP_BGE:  take_branch = ~sign_flag;
            OP_BLT:  take_branch = sign_flag;
            OP_BLE:  take_branch = sign_flag | zero_flag;
            OP_JMP:  take_branch = 1'b1;
            default: take_branch = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multicycle control FSM for the 11-bit accumulator processor.
// Optional instruction counter enabled with `define CONTROL_INSTR_COUNT_EN.
module control_unit
    import control_pkg::*;
#(
    parameter int OPCODE_WIDTH = 5,
    parameter int MEM_LATENCY  = 1
) (
    input  logic                    clock_in,
    input  logic                    reset_in,
    input  logic [OPCODE_WIDTH-1:0] opcode_in,
    input  logic                    zero_in,
    input  logic                    sign_in,
    output logic                    pc_write_out,
    output logic                    pc_src_out,
    output logic                    ir_write_out,
    output logic                    addr_src_out,
    output logic                    mem_read_out,
    output logic                    mem_write_out,
    output logic                    acc_write_out,
    output logic [1:0]              acc_src_out,
    output logic                    alu_b_src_out,
    output logic                    alu_op_out,
    output logic                    zero_flag_out,
    output logic                    sign_flag_out,
    output logic                    halted_out
`ifdef CONTROL_INSTR_COUNT_EN
    ,
    output logic [15:0]             instr_count_out
`endif
);

    localparam logic [2:0] LAST_BEAT = 3'(MEM_LATENCY - 1);

    state_t     state_r;
    state_t     next_state_s;
    logic [2:0] wait_cnt_r;
    logic [2:0] wait_cnt_next_s;
    logic       zero_flag_r;
    logic       sign_flag_r;
    logic       flag_load_s;
    logic       take_branch_s;
    logic       last_beat_s;
    logic [4:0] op_s;

    assign op_s        = 5'(opcode_in);
    assign last_beat_s = (wait_cnt_r == LAST_BEAT);

    branch_resolver u_branch_resolver (
        .opcode      (op_s),
        .zero_flag   (zero_flag_r),
        .sign_flag   (sign_flag_r),
        .take_branch (take_branch_s)
    );

    // State, memory wait counter and architectural flags.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_r     <= S_FETCH;
            wait_cnt_r  <= 3'd0;
            zero_flag_r <= 1'b0;
            sign_flag_r <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            wait_cnt_r <= wait_cnt_next_s;
            if (flag_load_s) begin
                zero_flag_r <= zero_in;
                sign_flag_r <= sign_in;
            end
        end
    end

    // Next-state and Moore output decode; reset forces every strobe and select low.
    always_comb begin
        next_state_s    = state_r;
        wait_cnt_next_s = wait_cnt_r;
        flag_load_s     = 1'b0;
        pc_write_out    = 1'b0;
        pc_src_out      = 1'b0;
        ir_write_out    = 1'b0;
        addr_src_out    = 1'b0;
        mem_read_out    = 1'b0;
        mem_write_out   = 1'b0;
        acc_write_out   = 1'b0;
        acc_src_out     = ACC_SRC_ALU;
        alu_b_src_out   = 1'b0;
        alu_op_out      = ALU_SOMA;
        halted_out      = 1'b0;

        if (reset_in) begin
            next_state_s    = S_FETCH;
            wait_cnt_next_s = 3'd0;
        end else begin
            case (state_r)
                S_FETCH: begin
                    mem_read_out = 1'b1;
                    if (last_beat_s) begin
                        ir_write_out    = 1'b1;
                        pc_write_out    = 1'b1;
                        wait_cnt_next_s = 3'd0;
                        next_state_s    = S_DECODE;
                    end else begin
                        wait_cnt_next_s = wait_cnt_r + 3'd1;
                        next_state_s    = S_FETCH;
                    end
                end
                S_DECODE: begin
                    wait_cnt_next_s = 3'd0;
                    if (op_s == OP_HLT) begin
                        next_state_s = S_HALT;
                    end else if (needs_mem_read(op_s)) begin
                        next_state_s = S_MEM;
                    end else begin
                        next_state_s = S_EXEC;
                    end
                end
                S_MEM: begin
                    addr_src_out = 1'b1;
                    mem_read_out = 1'b1;
                    if (last_beat_s) begin
                        wait_cnt_next_s = 3'd0;
                        next_state_s    = S_EXEC;
                    end else begin
                        wait_cnt_next_s = wait_cnt_r + 3'd1;
                        next_state_s    = S_MEM;
                    end
                end
                S_EXEC: begin
                    next_state_s    = S_FETCH;
                    wait_cnt_next_s = 3'd0;
                    flag_load_s     = is_arith(op_s);
                    case (op_s)
                        OP_STO: begin
                            addr_src_out  = 1'b1;
                            mem_write_out = 1'b1;
                        end
                        OP_LD: begin
                            acc_write_out = 1'b1;
                            acc_src_out   = ACC_SRC_MEM;
                            addr_src_out  = 1'b1;
                        end
                        OP_LDI: begin
                            acc_write_out = 1'b1;
                            acc_src_out   = ACC_SRC_IMM;
                        end
                        OP_ADD, OP_SUB, OP_ADDI, OP_SUBI: begin
                            acc_write_out = 1'b1;
                            acc_src_out   = ACC_SRC_ALU;
                            addr_src_out  = 1'b1;
                            alu_b_src_out = (op_s == OP_ADDI) || (op_s == OP_SUBI);
                            alu_op_out    = ((op_s == OP_SUB) || (op_s == OP_SUBI)) ? ALU_SUBT : ALU_SOMA;
                        end
                        OP_BEQ, OP_BNE, OP_BGT, OP_BGE, OP_BLT, OP_BLE, OP_JMP: begin
                            pc_write_out = take_branch_s;
                            pc_src_out   = take_branch_s;
                        end
                        default: begin
                            pc_write_out = 1'b0;
                        end
                    endcase
                end
                S_HALT: begin
                    halted_out   = 1'b1;
                    next_state_s = S_HALT;
                end
                default: begin
                    next_state_s    = S_FETCH;
                    wait_cnt_next_s = 3'd0;
                end
            endcase
        end
    end

    assign zero_flag_out = zero_flag_r;
    assign sign_flag_out = sign_flag_r;

`ifdef CONTROL_INSTR_COUNT_EN
    logic [15:0] instr_count_r;

    // Executed-instruction counter; HLT never reaches S_EXEC so it is not counted.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            instr_count_r <= 16'd0;
        end else if (state_r == S_EXEC) begin
            instr_count_r <= instr_count_r + 16'd1;
        end
    end

    assign instr_count_out = instr_count_r;
`else
    // No instruction counter in this build.
`endif

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multicycle control FSM for the 11-bit accumulator processor.
- Sequences instruction fetch, decode, operand read, ALU operation and accumulator/PC/memory writes.
- Drives the ALU operation select (0 = add, 1 = sub).
- Holds the architectural zero/sign flags, latched from the ALU zero and sign outputs, and resolves conditional branches from them.
- Sits between the instruction register opcode field and the datapath muxes, register enables and the data/instruction memory strobes.

Parameters:
- OPCODE_WIDTH, 5, width of the instruction opcode field.
- MEM_LATENCY, 1, cycles a memory read takes; legal range 1..7. Sizes the 3-bit wait counter.

Ports:
- clock_in  input  1  system clock; all state updates on the rising edge.
- reset_in  input  1  synchronous, active-high reset.
- opcode_in  input  OPCODE_WIDTH  opcode field from the instruction register.
- zero_in  input  1  ALU zero indicator.
- sign_in  input  1  ALU sign bit (MSB of the ALU result).
- pc_write_out  output  1  PC load enable.
- pc_src_out  output  1  0 = PC+1, 1 = branch target (operand).
- ir_write_out  output  1  instruction register load enable.
- addr_src_out  output  1  memory address select: 0 = PC, 1 = operand.
- mem_read_out  output  1  memory read strobe.
- mem_write_out  output  1  memory write strobe (accumulator to memory[operand]).
- acc_write_out  output  1  accumulator load enable.
- acc_src_out  output  2  accumulator source: 00 = ALU, 01 = memory data, 10 = immediate operand.
- alu_b_src_out  output  1  ALU B input select: 0 = memory data, 1 = immediate.
- alu_op_out  output  1  ALU operation: 0 = add, 1 = subtract.
- zero_flag_out  output  1  registered zero flag.
- sign_flag_out  output  1  registered sign flag.
- halted_out  output  1  high while the FSM is in S_HALT.

Behaviour:
- Reset:
  - reset_in high at an edge sets state = S_FETCH, wait_cnt = 0, zero_flag_out = 0, sign_flag_out = 0.
  - All strobes and enables are 0 and every select is 0 during the reset cycle.
  - Reset overrides everything, including a transfer in progress and S_HALT.
- Opcodes:
  - 00000 HLT, 00001 STO, 00010 LD, 00011 LDI, 00100 ADD, 00101 ADDI, 00110 SUB, 00111 SUBI.
  - 01000 BEQ, 01001 BNE, 01010 BGT, 01011 BGE, 01100 BLT, 01101 BLE, 01110 JMP.
  - Any other opcode executes as a NOP.
- S_FETCH:
  - addr_src_out = 0, mem_read_out = 1 for MEM_LATENCY cycles.
  - In the final cycle (wait_cnt == MEM_LATENCY-1): ir_write_out = 1, pc_write_out = 1, pc_src_out = 0.
  - Then wait_cnt = 0 and state goes to S_DECODE.
- S_DECODE (1 cycle, all strobes 0):
  - HLT goes to S_HALT.
  - LD, ADD and SUB go to S_MEM.
  - STO, LDI, ADDI, SUBI, branches, JMP and NOPs go to S_EXEC.
- S_MEM:
  - addr_src_out = 1, mem_read_out = 1 for MEM_LATENCY cycles, then S_EXEC.
- S_EXEC (1 cycle, always returns to S_FETCH):
  - STO: addr_src_out = 1, mem_write_out = 1.
  - LD: acc_write_out = 1, acc_src_out = 01, addr_src_out = 1.
  - LDI: acc_write_out = 1, acc_src_out = 10.
  - ADD / SUB: alu_b_src_out = 0, alu_op_out = 0 / 1, acc_src_out = 00, acc_write_out = 1, addr_src_out = 1.
  - ADDI / SUBI: same as ADD / SUB but alu_b_src_out = 1.
  - Arithmetic ops also latch zero_flag_out <= zero_in and sign_flag_out <= sign_in at the end of S_EXEC. No other opcode touches the flags.
  - Branches: pc_write_out = 1 and pc_src_out = 1 if the condition holds on the registered flags (Z = zero flag, N = sign flag):
    - BEQ: Z. BNE: !Z. BGT: !Z & !N. BGE: !N. BLT: N. BLE: N | Z.
  - JMP: pc_write_out = 1, pc_src_out = 1, unconditional.
  - NOP: no strobes.
- S_HALT: all strobes 0, halted_out = 1; only reset exits.
- Latency: with MEM_LATENCY = L, immediate/branch/STO instructions take L+2 cycles; LD/ADD/SUB take 2L+2 cycles.
- Outputs are Moore-decoded from state, registered opcode-independent wait_cnt and opcode_in.
  - opcode_in must remain stable from S_DECODE through S_EXEC; this holds because the IR loads only in S_FETCH.
- Branch conditions use the flags produced by the most recent arithmetic instruction, not the current ALU output.

Optional Feature:
- Macro CONTROL_INSTR_COUNT_EN.
- Defined:
  - Adds output instr_count_out, 16 bits, reset to 0.
  - Increments by 1 on every S_EXEC cycle and wraps from 0xFFFF to 0.
  - HLT is not counted.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package control_pkg holds:
  - The state enum (S_FETCH, S_DECODE, S_MEM, S_EXEC, S_HALT).
  - Opcode localparams.
  - acc_src encodings.
  - ALU op encodings _soma = 1'b0, _subt = 1'b1, shared with the ALU.
- One natural sub-module: branch_resolver.
  - Combinational; inputs opcode and registered flags; output take_branch.
- The FSM, wait counter and flag registers stay in control_unit.

Test Plan:
- Reset / fetch: MEM_LATENCY = 1, reset_in high 2 cycles then low.
  - Required: the first cycle after release is S_FETCH with mem_read_out = 1, ir_write_out = 1, pc_write_out = 1; the next cycle is S_DECODE with all strobes 0.
- ADD sequence: opcode 00100, zero_in = 1, sign_in = 0 at S_EXEC.
  - Required: S_MEM shows addr_src_out = 1, mem_read_out = 1.
  - Required: S_EXEC shows acc_write_out = 1, alu_op_out = 0, alu_b_src_out = 0.
  - Required: afterwards zero_flag_out = 1, sign_flag_out = 0; total 4 cycles.
- Branches: after SUBI sets N = 1, Z = 0:
  - BLT gives pc_write_out = 1, pc_src_out = 1 in S_EXEC.
  - BGE gives pc_write_out = 0.
  - BLE is taken, BEQ is not taken.
- Latency: MEM_LATENCY = 3, LD instruction.
  - Required: mem_read_out high 3 cycles in fetch and 3 in S_MEM; acc_src_out = 01 with acc_write_out = 1 in S_EXEC; total 8 cycles.
- Halt / reset mid-operation:
  - HLT gives halted_out = 1, held 20 cycles with no strobes.
  - reset_in during S_MEM of an ADD gives no acc_write_out pulse, flags = 0, and fetch restarts.
- CONTROL_INSTR_COUNT_EN defined: 5 instructions then HLT.
  - Required: instr_count_out = 5 and stays 5.
